// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for seg7_scan_driver: digit data and controls in,
// segment/anode pins and status out.
interface seg7_scan_driver_if #(
   parameter int unsigned DIGITS = 8
);
   logic [4*DIGITS-1:0] data_in;
   logic                load;
   logic                en;
   logic [DIGITS-1:0]   blank;
   logic [6:0]          hex;
   logic [DIGITS-1:0]   AN;
   logic                frame_tick;
   logic                pending;

   modport master (
      output data_in, load, en, blank,
      input  hex, AN, frame_tick, pending
   );

   modport slave (
      input  data_in, load, en, blank,
      output hex, AN, frame_tick, pending
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
// Define LEAD_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always shown).
module seg7_scan_driver #(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input logic                clk,
   input logic                rst_n,
   seg7_scan_driver_if.slave  bus
);
   localparam int unsigned    PSC_W    = $clog2(REFRESH_DIV);
   localparam int unsigned    IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(REFRESH_DIV - 1);
   localparam logic [PSC_W-1:0] PSC_PRE  = PSC_W'(REFRESH_DIV - 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PSC_W-1:0]    psc_q;
   logic [IDX_W-1:0]    idx_q;
   logic [4*DIGITS-1:0] active_q;
   logic [4*DIGITS-1:0] pend_buf_q;
   logic                pending_q;
   logic                tick_q;
   logic [6:0]          hex_q;
   logic [DIGITS-1:0]   an_q;

   logic                psc_tc;
   logic                boundary;
   logic                tick_d;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic                dark;
   logic [DIGITS-1:0]   lz_dark;

`ifdef LEAD_ZERO_BLANK_EN
   // Walk down from the top digit; a digit is dark while everything above it is zero.
   always_comb begin
      logic zeros;
      zeros   = 1'b1;
      lz_dark = '0;
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
         zeros      = zeros & (active_q[4*i +: 4] == 4'h0);
         lz_dark[i] = zeros;
      end
   end
`else
   assign lz_dark = '0;
`endif

   always_comb begin
      psc_tc   = (psc_q == PSC_LAST);
      boundary = psc_tc && (idx_q == IDX_LAST);
      // Registered one cycle early so the pulse lands on the wrap cycle itself.
      tick_d   = (psc_q == PSC_PRE) && (idx_q == IDX_LAST);
      nibble   = active_q[4*idx_q +: 4];
      dark     = !bus.en || bus.blank[idx_q] || lz_dark[idx_q];
      glyph    = 7'h7F;
      case (nibble)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q      <= '0;
         idx_q      <= '0;
         active_q   <= '0;
         pend_buf_q <= '0;
         pending_q  <= 1'b0;
         tick_q     <= 1'b0;
         hex_q      <= 7'h7F;
         an_q       <= '1;
      end else begin
         psc_q <= psc_tc ? '0 : psc_q + 1'b1;
         if (psc_tc) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end

         // A load on the boundary bypasses the pending buffer and wins over it.
         if (boundary) begin
            if (bus.load) begin
               active_q <= bus.data_in;
            end else if (pending_q) begin
               active_q <= pend_buf_q;
            end
            pending_q <= 1'b0;
         end else if (bus.load) begin
            pend_buf_q <= bus.data_in;
            pending_q  <= 1'b1;
         end

         tick_q <= tick_d;
         hex_q  <= dark ? 7'h7F : glyph;
         an_q   <= dark ? '1 : ~(DIGITS'(1) << idx_q);
      end
   end

   assign bus.hex        = hex_q;
   assign bus.AN         = an_q;
   assign bus.frame_tick = tick_q;
   assign bus.pending    = pending_q;
endmodule
